// File: rtl/sha256_msg_sequencer_pkg.sv
// Purpose : shared encodings and constants for the SHA-256 message sequencer.
// Latency : n/a (types, constants and one pure helper function).
// Backpress: n/a.
// Contents: state_t FSM encoding, idx_t schedule index, PAD_WORD, length slot indices.
package sha256_pkg;

   localparam int BLOCK_WORDS = 16;
   localparam int IDX_W       = $clog2(BLOCK_WORDS);

   typedef logic [IDX_W-1:0] idx_t;

   localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
   localparam idx_t        IDX_LEN_HI = idx_t'(14);
   localparam idx_t        IDX_LEN_LO = idx_t'(15);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_PAD,
      ST_ZERO,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_WAIT_CORE
   } state_t;

   // Phase that follows a pad/zero word emitted at 'idx': the length pair
   // must start exactly at IDX_LEN_HI, everything before it is zero fill.
   function automatic state_t fill_next(input idx_t idx);
      return (idx == IDX_LEN_HI - idx_t'(1)) ? ST_LEN_HI : ST_ZERO;
   endfunction

endpackage

// File: rtl/sha256_msg_sequencer_if.sv
// Purpose : message-in / schedule-out bundle between producer, sequencer and SHA-256 core.
// Latency : n/a (wiring only).
// Backpress: IN_READY gates input transfers; the core side has no backpressure.
// Ports   : master = producer + core side, slave = sequencer side.
interface sha256_msg_sequencer_if;
   import sha256_pkg::*;

   logic [31:0] IN_WORD;
   logic        IN_VALID;
   logic        IN_LAST;
   logic        IN_READY;
   logic [31:0] OUT_WORD;
   logic        OUT_VALID;
   idx_t        OUT_IDX;
   logic        BLK_START;
   logic        BLK_LAST;
   logic        CORE_DONE;
   logic        BUSY;

   modport master (
      output IN_WORD, IN_VALID, IN_LAST, CORE_DONE,
      input  IN_READY, OUT_WORD, OUT_VALID, OUT_IDX, BLK_START, BLK_LAST, BUSY
   );

   modport slave (
      input  IN_WORD, IN_VALID, IN_LAST, CORE_DONE,
      output IN_READY, OUT_WORD, OUT_VALID, OUT_IDX, BLK_START, BLK_LAST, BUSY
   );

endinterface

// File: rtl/sha256_msg_sequencer_len_counter.sv
// Purpose : 32-bit accepted-word counter, presented as the two SHA-256 length words.
// Latency : count updates on the clock after inc_i; length words are combinational from it.
// Backpress: none; clr_i has priority over inc_i.
// Ports   : clk, rst_n, clr_i, inc_i -> len_hi_o {27'b0,cnt[31:27]}, len_lo_o {cnt[26:0],5'b0}.
module sha256_len_counter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        inc_i,
   output logic [31:0] len_hi_o,
   output logic [31:0] len_lo_o
);

   logic [31:0] cnt_q, cnt_d;

   // Wraps silently at 2^32 words; longer messages are out of scope.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Bit length = words * 32, split across the high and low length words.
   assign len_hi_o = {27'b0, cnt_q[31:27]};
   assign len_lo_o = {cnt_q[26:0], 5'b0};

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Purpose : turns a word stream into padded, length-terminated 16-word SHA-256 blocks.
// Latency : accepted word -> OUT_VALID 1 cycle later; padding/length words one per cycle.
// Backpress: IN_READY low while padding or waiting on CORE_DONE; core side never stalls.
// Ports   : C clock, R async active-low reset, bus (slave modport) carries stream + schedule.
module sha256_msg_sequencer
   import sha256_pkg::*;
(
   input  logic                   C,
   input  logic                   R,
   sha256_msg_sequencer_if.slave  bus
);

   state_t state_q, state_d;
   state_t resume_q, resume_d;
   idx_t   idx_q, idx_d;
   logic   final_q, final_d;
   logic   busy_q, busy_d;

   logic [31:0] out_word_q;
   logic        out_valid_q;
   idx_t        out_idx_q;
   logic        blk_start_q;
   logic        blk_last_q;

   logic        in_ready;
   logic        emit;
   logic [31:0] emit_word;
   logic        emit_last;
   logic        fin_done;
   logic        cnt_inc;
   state_t      nxt;
   logic [31:0] len_hi, len_lo;

   sha256_len_counter u_len_counter (
      .clk      (C),
      .rst_n    (R),
      .clr_i    (fin_done),
      .inc_i    (cnt_inc),
      .len_hi_o (len_hi),
      .len_lo_o (len_lo)
   );

   // Only IDLE and DATA consume input; IDLE always starts at idx 0 so both
   // states share the same accept path.
   assign in_ready = (state_q == ST_IDLE) || (state_q == ST_DATA);

   always_comb begin
      state_d   = state_q;
      resume_d  = resume_q;
      idx_d     = idx_q;
      final_d   = final_q;
      busy_d    = busy_q;
      emit      = 1'b0;
      emit_word = '0;
      emit_last = 1'b0;
      fin_done  = 1'b0;
      cnt_inc   = 1'b0;
      nxt       = ST_IDLE;

      case (state_q)
         ST_IDLE, ST_DATA: begin
            if (bus.IN_VALID) begin
               emit      = 1'b1;
               emit_word = bus.IN_WORD;
               cnt_inc   = 1'b1;
               busy_d    = 1'b1;
               nxt       = bus.IN_LAST ? ST_PAD : ST_DATA;
            end
         end
         ST_PAD: begin
            emit      = 1'b1;
            emit_word = PAD_WORD;
            nxt       = fill_next(idx_q);
         end
         ST_ZERO: begin
            emit      = 1'b1;
            emit_word = '0;
            nxt       = fill_next(idx_q);
         end
         ST_LEN_HI: begin
            emit      = 1'b1;
            emit_word = len_hi;
            nxt       = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            emit      = 1'b1;
            emit_word = len_lo;
            emit_last = 1'b1;
            nxt       = ST_IDLE;
         end
         ST_WAIT_CORE: begin
            if (bus.CORE_DONE) begin
               idx_d = '0;
               if (final_q) begin
                  state_d  = ST_IDLE;
                  final_d  = 1'b0;
                  busy_d   = 1'b0;
                  fin_done = 1'b1;
               end else begin
                  state_d = resume_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A word in the last slot closes the block: park in WAIT_CORE and
      // remember which phase to pick up at idx 0 of the next block.
      if (emit) begin
         idx_d = idx_q + idx_t'(1);
         if (idx_q == IDX_LEN_LO) begin
            state_d  = ST_WAIT_CORE;
            resume_d = nxt;
            final_d  = emit_last;
         end else begin
            state_d = nxt;
         end
      end
   end

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         state_q  <= ST_IDLE;
         resume_q <= ST_IDLE;
         idx_q    <= '0;
         final_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         idx_q    <= idx_d;
         final_q  <= final_d;
         busy_q   <= busy_d;
      end
   end

   // Registered core-side outputs: word and index hold between strobes,
   // index returns to 0 once the final block is retired.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         out_word_q  <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         blk_start_q <= 1'b0;
         blk_last_q  <= 1'b0;
      end else begin
         out_valid_q <= emit;
         blk_start_q <= emit && (idx_q == '0);
         blk_last_q  <= emit_last;
         if (emit) begin
            out_word_q <= emit_word;
            out_idx_q  <= idx_q;
         end else if (fin_done) begin
            out_idx_q  <= '0;
         end
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_WORD  = out_word_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.OUT_IDX   = out_idx_q;
   assign bus.BLK_START = blk_start_q;
   assign bus.BLK_LAST  = blk_last_q;
   assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Purpose : directed self-checking bench for sha256_msg_sequencer.
// Latency : inputs driven and outputs sampled on the falling edge of C.
// Backpress: bench honours IN_READY; CORE_DONE pulsed by the bench as the core.
module tb_sha256_msg_sequencer;
   import sha256_pkg::*;

   logic C = 1'b0;
   logic R;
   int   checks = 0;
   int   errors = 0;

   sha256_msg_sequencer_if bus ();

   sha256_msg_sequencer dut (
      .C   (C),
      .R   (R),
      .bus (bus)
   );

   always #5 C = ~C;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] w, input idx_t idx,
                           input logic s, input logic l);
      string t;
      t = $sformatf("%s[%0d]", tag, idx);
      chk({t, ":valid"}, 32'(bus.OUT_VALID), 32'd1);
      chk({t, ":word"},  bus.OUT_WORD,       w);
      chk({t, ":idx"},   32'(bus.OUT_IDX),   32'(idx));
      chk({t, ":start"}, 32'(bus.BLK_START), 32'(s));
      chk({t, ":last"},  32'(bus.BLK_LAST),  32'(l));
   endtask

   // Drive one word for one clock, then check it on the core side.
   task automatic send_chk(input string tag, input logic [31:0] w, input logic last,
                           input idx_t idx, input logic s);
      chk({tag, ":ready"}, 32'(bus.IN_READY), 32'd1);
      bus.IN_WORD  = w;
      bus.IN_LAST  = last;
      bus.IN_VALID = 1'b1;
      @(negedge C);
      bus.IN_VALID = 1'b0;
      bus.IN_LAST  = 1'b0;
      chk_word(tag, w, idx, s, 1'b0);
   endtask

   task automatic pad_chk(input string tag, input logic [31:0] w, input idx_t idx,
                          input logic s, input logic l);
      @(negedge C);
      chk_word(tag, w, idx, s, l);
   endtask

   task automatic core_done_pulse();
      bus.CORE_DONE = 1'b1;
      @(negedge C);
      bus.CORE_DONE = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ":busy"},  32'(bus.BUSY),     32'd0);
      chk({tag, ":ready"}, 32'(bus.IN_READY), 32'd1);
      chk({tag, ":idx"},   32'(bus.OUT_IDX),  32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      R             = 1'b0;
      bus.IN_WORD   = '0;
      bus.IN_VALID  = 1'b0;
      bus.IN_LAST   = 1'b0;
      bus.CORE_DONE = 1'b0;
      #1;
      chk("rst:valid", 32'(bus.OUT_VALID), 32'd0);
      chk("rst:word",  bus.OUT_WORD,       32'd0);
      chk("rst:idx",   32'(bus.OUT_IDX),   32'd0);
      chk("rst:start", 32'(bus.BLK_START), 32'd0);
      chk("rst:last",  32'(bus.BLK_LAST),  32'd0);
      chk("rst:busy",  32'(bus.BUSY),      32'd0);
      repeat (2) @(negedge C);
      R = 1'b1;
      chk("rst:ready", 32'(bus.IN_READY), 32'd1);

      // One-word message: data, pad, zeros, length 32 bits.
      send_chk("t1", 32'h0000_0001, 1'b1, idx_t'(0), 1'b1);
      chk("t1:busy", 32'(bus.BUSY), 32'd1);
      pad_chk("t1", 32'h8000_0000, idx_t'(1), 1'b0, 1'b0);
      for (int i = 2; i <= 14; i++) pad_chk("t1", 32'h0, idx_t'(i), 1'b0, 1'b0);
      pad_chk("t1", 32'h0000_0020, idx_t'(15), 1'b0, 1'b1);
      @(negedge C);
      chk("t1w:valid", 32'(bus.OUT_VALID), 32'd0);
      chk("t1w:ready", 32'(bus.IN_READY),  32'd0);
      chk("t1w:busy",  32'(bus.BUSY),      32'd1);
      core_done_pulse();
      chk_idle("t1end");

      // 14 words: pad at 14, zero at 15, second block zeros + length 448.
      for (int i = 0; i < 14; i++)
         send_chk("t2", 32'hA000_0000 + 32'(i), (i == 13), idx_t'(i), (i == 0));
      pad_chk("t2", 32'h8000_0000, idx_t'(14), 1'b0, 1'b0);
      pad_chk("t2", 32'h0, idx_t'(15), 1'b0, 1'b0);
      bus.IN_WORD  = 32'hDEAD_BEEF;
      bus.IN_VALID = 1'b1;
      @(negedge C);
      chk("t2w:valid", 32'(bus.OUT_VALID), 32'd0);
      chk("t2w:ready", 32'(bus.IN_READY),  32'd0);
      @(negedge C);
      chk("t2w:valid2", 32'(bus.OUT_VALID), 32'd0);
      core_done_pulse();
      bus.IN_VALID = 1'b0;
      pad_chk("t2b", 32'h0, idx_t'(0), 1'b1, 1'b0);
      for (int i = 1; i <= 14; i++) pad_chk("t2b", 32'h0, idx_t'(i), 1'b0, 1'b0);
      pad_chk("t2b", 32'h0000_01C0, idx_t'(15), 1'b0, 1'b1);
      core_done_pulse();
      chk_idle("t2end");

      // 16 words: full data block, then pad block with length 512.
      for (int i = 0; i < 16; i++)
         send_chk("t3", 32'h0300_0000 + 32'(i), (i == 15), idx_t'(i), (i == 0));
      chk("t3w:ready", 32'(bus.IN_READY), 32'd0);
      core_done_pulse();
      pad_chk("t3b", 32'h8000_0000, idx_t'(0), 1'b1, 1'b0);
      for (int i = 1; i <= 14; i++) pad_chk("t3b", 32'h0, idx_t'(i), 1'b0, 1'b0);
      pad_chk("t3b", 32'h0000_0200, idx_t'(15), 1'b0, 1'b1);
      core_done_pulse();
      chk_idle("t3end");

      // Sparse input (1 of 3 cycles): no bubbles in idx, then padding back-to-back.
      for (int k = 1; k <= 5; k++) begin
         send_chk("t4", 32'(k) * 32'h1111_1111, (k == 5), idx_t'(k - 1), (k == 1));
         if (k != 5) begin
            @(negedge C);
            chk("t4gap:valid", 32'(bus.OUT_VALID), 32'd0);
            @(negedge C);
            chk("t4gap:valid", 32'(bus.OUT_VALID), 32'd0);
         end
      end
      pad_chk("t4", 32'h8000_0000, idx_t'(5), 1'b0, 1'b0);
      for (int i = 6; i <= 14; i++) pad_chk("t4", 32'h0, idx_t'(i), 1'b0, 1'b0);
      pad_chk("t4", 32'h0000_00A0, idx_t'(15), 1'b0, 1'b1);
      core_done_pulse();
      chk_idle("t4end");

      // Stray CORE_DONE during DATA, then reset at idx 7 aborts the message.
      for (int i = 0; i < 8; i++) begin
         bus.CORE_DONE = (i == 3);
         send_chk("t5", 32'h0500_0000 + 32'(i), 1'b0, idx_t'(i), (i == 0));
         bus.CORE_DONE = 1'b0;
      end
      chk("t5:busy", 32'(bus.BUSY), 32'd1);
      R = 1'b0;
      #1;
      chk("t5rst:valid", 32'(bus.OUT_VALID), 32'd0);
      chk("t5rst:word",  bus.OUT_WORD,       32'd0);
      chk("t5rst:idx",   32'(bus.OUT_IDX),   32'd0);
      chk("t5rst:start", 32'(bus.BLK_START), 32'd0);
      chk("t5rst:last",  32'(bus.BLK_LAST),  32'd0);
      chk("t5rst:busy",  32'(bus.BUSY),      32'd0);
      @(negedge C);
      R = 1'b1;
      chk("t5rel:ready", 32'(bus.IN_READY), 32'd1);
      @(negedge C);
      chk("t5rel:valid", 32'(bus.OUT_VALID), 32'd0);
      send_chk("t5n", 32'h1234_5678, 1'b1, idx_t'(0), 1'b1);
      pad_chk("t5n", 32'h8000_0000, idx_t'(1), 1'b0, 1'b0);
      for (int i = 2; i <= 14; i++) pad_chk("t5n", 32'h0, idx_t'(i), 1'b0, 1'b0);
      pad_chk("t5n", 32'h0000_0020, idx_t'(15), 1'b0, 1'b1);
      core_done_pulse();
      chk_idle("t5end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sequencer.md
SHA256_MSG_SEQUENCER -- requirements
Module: sha256_msg_sequencer

Interface
REQ-001 C  in  1  clock; all state updates on posedge C.
REQ-002 R  in  1  reset, asynchronous, active-low.
REQ-003 IN_WORD  in  32  message data word, big-endian bit order.
REQ-004 IN_VALID  in  1  IN_WORD valid.
REQ-005 IN_LAST  in  1  qualifies IN_WORD as final message word; meaningful only with IN_VALID.
REQ-006 IN_READY  out  1  sequencer accepts a word this cycle; transfer = IN_VALID & IN_READY.
REQ-007 OUT_WORD  out  32  word presented to SHA256 core (data, pad or length).
REQ-008 OUT_VALID  out  1  one-cycle strobe per OUT_WORD; core accepts unconditionally.
REQ-009 OUT_IDX  out  4  schedule index 0..15 of OUT_WORD within the current 512-bit block.
REQ-010 BLK_START  out  1  high with the OUT_IDX=0 word of every block.
REQ-011 BLK_LAST  out  1  high with the OUT_IDX=15 word of the final block of a message.
REQ-012 CORE_DONE  in  1  one-cycle pulse: core finished compressing the current block.
REQ-013 BUSY  out  1  high from first accepted word until CORE_DONE of final block.

Function
REQ-014 States: IDLE, DATA, PAD, ZERO, LEN_HI, LEN_LO, WAIT_CORE; one-hot or binary, registered.
REQ-015 IDLE: IN_READY=1; an accepted word moves to DATA processing; BUSY rises the cycle after acceptance.
REQ-016 DATA: IN_READY=1 except while OUT_IDX would exceed 15; each accepted word appears on OUT_WORD with OUT_VALID exactly 1 cycle later; no IN_VALID -> no OUT_VALID (stall, no bubbles inserted).
REQ-017 OUT_IDX increments per OUT_VALID, wraps 15->0; after the idx-15 word, state enters WAIT_CORE and IN_READY=0 until CORE_DONE.
REQ-018 WAIT_CORE: on CORE_DONE return to the interrupted phase (DATA, PAD, ZERO or LEN_HI) at idx 0, or to IDLE if the block was final.
REQ-019 Word counter: 32 bits, counts accepted data words, wraps silently at 2^32 (longer messages unsupported).
REQ-020 After last data word at idx i: PAD emits 32'h8000_0000 at idx i+1 (idx 0 of next block if i=15).
REQ-021 ZERO emits 32'h0000_0000 until idx 13 inclusive; if pad landed at idx 14 or 15, zeros fill to 15, then a full new block of zeros 0..13.
REQ-022 LEN_HI at idx 14 = {27'b0, cnt[31:27]}; LEN_LO at idx 15 = {cnt[26:0], 5'b0} (bit length = words*32); BLK_LAST with LEN_LO.
REQ-023 Padding words emitted one per cycle, no input dependency.
REQ-024 CORE_DONE outside WAIT_CORE ignored; IN_VALID outside IN_READY ignored (word not consumed).
REQ-025 Empty messages not supported; every message has at least one word carrying IN_LAST.
REQ-026 Final CORE_DONE -> IDLE, BUSY=0, OUT_IDX=0, counter cleared next cycle; new message accepted from the following cycle.

Reset
REQ-027 R low: immediately state=IDLE, OUT_WORD=0, OUT_VALID=0, OUT_IDX=0, BLK_START=0, BLK_LAST=0, BUSY=0, counter=0; IN_READY=1 once R high.
REQ-028 Reset mid-message aborts it; no partial block or padding emitted afterwards.

Structure
REQ-029 Shared package sha256_pkg holds state encoding, PAD_WORD=32'h8000_0000, IDX_LEN_HI=14, IDX_LEN_LO=15, BLOCK_WORDS=16.
REQ-030 One sub-module sha256_len_counter: 32-bit word counter (clear, increment) producing LEN_HI/LEN_LO words.

Verification
REQ-031 One word 32'h0000_0001+LAST -> idx0 0x00000001 (BLK_START), idx1 0x80000000, idx2..14 0, idx15 0x00000020 with BLK_LAST; CORE_DONE -> BUSY=0.
REQ-032 14 words, LAST on 14th -> idx14 0x80000000, idx15 0, WAIT_CORE; after CORE_DONE block 2: idx0..14 0, idx15 0x000001C0, BLK_LAST.
REQ-033 16 words -> block 1 data only, no BLK_LAST; block 2 idx0 0x80000000, idx1..14 0, idx15 0x00000200.
REQ-034 IN_VALID toggled 1-of-3 cycles over 5 words -> OUT_VALID mirrors accepts 1 cycle later, OUT_IDX 0..4 contiguous, then padding back-to-back.
REQ-035 CORE_DONE pulsed during DATA -> no effect; R low at idx 7 -> all outputs 0 same cycle, next message starts at idx 0 with count 1.
